mips_regfile_decode: RTL and testbench

//  Parametrised decode/register-read stage for the MIPS datapath. Slices the instruction
//  and holds the full architectural register file with a write-back port. Produces

---
 rtl/mips_pkg.sv | 23 ++
 rtl/mips_regfile_decode_if.sv | 20 ++
 rtl/mips_regfile_core.sv | 38 +++
 rtl/mips_regfile_decode.sv | 67 ++++++
 tb/tb_mips_regfile_decode.sv | 168 ++++++++++++++++
 5 files changed

// File: rtl/mips_pkg.sv
// mips_pkg: opcodes, instruction field positions and register names for the MIPS decode stage.
package mips_pkg;
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_ANDI  = 6'h0C;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam int OPC_LSB = 26;
  localparam int OPC_W   = 6;
  localparam int RS_LSB  = 21;
  localparam int RT_LSB  = 16;
  localparam int RD_LSB  = 11;
  localparam int IMM_W   = 16;
  localparam int FUNCT_W = 6;
  localparam int REG_ZERO = 0;
  localparam int REG_T0 = 8,  REG_T1 = 9,  REG_T2 = 10, REG_T3 = 11;
  localparam int REG_T4 = 12, REG_T5 = 13, REG_T6 = 14, REG_T7 = 15;
  localparam int REG_S0 = 16, REG_S1 = 17, REG_S2 = 18, REG_S3 = 19;
  localparam int REG_S4 = 20, REG_S5 = 21, REG_S6 = 22, REG_S7 = 23;
endpackage

// File: rtl/mips_regfile_decode_if.sv
// mips_regfile_decode_if: issue, write-back and operand bus of the decode/register-read stage.
interface mips_regfile_decode_if #(parameter int DATA_W = 32, parameter int AW = 5);
  logic              in_valid;
  logic [31:0]       instruction;
  logic              stall;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              out_valid;
  logic [DATA_W-1:0] operand1;
  logic [DATA_W-1:0] operand2;
  logic [DATA_W-1:0] store_data;
  logic [AW-1:0]     dest_reg;
  logic [5:0]        funct;
  logic [5:0]        opcode_q;
  modport master (output in_valid, instruction, stall, wr_en, wr_addr, wr_data,
                  input out_valid, operand1, operand2, store_data, dest_reg, funct, opcode_q);
  modport slave (input in_valid, instruction, stall, wr_en, wr_addr, wr_data,
                 output out_valid, operand1, operand2, store_data, dest_reg, funct, opcode_q);
endinterface

// File: rtl/mips_regfile_core.sv
// mips_regfile_core: register array with one write port, two combinational reads, reg 0 hardwired zero.
// REGFILE_BYPASS_EN forwards a same-edge write to matching nonzero read ports.
module mips_regfile_core import mips_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32,
  localparam int AW = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [AW-1:0]     wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [AW-1:0]     ra_addr,
  output logic [DATA_W-1:0] ra_data,
  input  logic [AW-1:0]     rb_addr,
  output logic [DATA_W-1:0] rb_data
);
`ifdef REGFILE_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif
  logic [DATA_W-1:0] regs_q [NUM_REGS];
  logic [DATA_W-1:0] regs_d [NUM_REGS];
  logic wr_ok;
  assign wr_ok = wr_en && wr_addr != AW'(REG_ZERO);
  always_comb begin
    regs_d = regs_q;
    if (wr_ok) regs_d[wr_addr] = wr_data;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) regs_q <= '{default: '0};
    else regs_q <= regs_d;
  always_comb begin
    ra_data = ra_addr == AW'(REG_ZERO) ? '0 : (BYPASS && wr_ok && wr_addr == ra_addr) ? wr_data : regs_q[ra_addr];
    rb_data = rb_addr == AW'(REG_ZERO) ? '0 : (BYPASS && wr_ok && wr_addr == rb_addr) ? wr_data : regs_q[rb_addr];
  end
endmodule

// File: rtl/mips_regfile_decode.sv
// mips_regfile_decode: instruction slicing, register read, immediate extension and stallable output register.
// Optional REGFILE_BYPASS_EN enables write-through forwarding in the register file.
module mips_regfile_decode import mips_pkg::*; #(
  parameter int DATA_W = 32,
  parameter int NUM_REGS = 32
) (
  input logic clk,
  input logic rst_n,
  mips_regfile_decode_if.slave bus
);
  localparam int AW = $clog2(NUM_REGS);
  logic [OPC_W-1:0] opc;
  logic [AW-1:0] rs, rt, rd;
  logic [IMM_W-1:0] imm;
  logic [DATA_W-1:0] rs_data, rt_data, imm_ext;
  logic valid_q, valid_d;
  logic [DATA_W-1:0] op1_q, op1_d, op2_q, op2_d, sdata_q, sdata_d;
  logic [AW-1:0] dest_q, dest_d;
  logic [FUNCT_W-1:0] funct_q, funct_d;
  logic [OPC_W-1:0] opc_q, opc_d;
  assign opc = bus.instruction[OPC_LSB +: OPC_W];
  assign rs  = bus.instruction[RS_LSB +: AW];
  assign rt  = bus.instruction[RT_LSB +: AW];
  assign rd  = bus.instruction[RD_LSB +: AW];
  assign imm = bus.instruction[IMM_W-1:0];
  mips_regfile_core #(.DATA_W(DATA_W), .NUM_REGS(NUM_REGS)) u_core (
    .clk(clk), .rst_n(rst_n),
    .wr_en(bus.wr_en), .wr_addr(bus.wr_addr), .wr_data(bus.wr_data),
    .ra_addr(rs), .ra_data(rs_data),
    .rb_addr(rt), .rb_data(rt_data)
  );
  always_comb begin
    imm_ext = (opc == OP_ANDI || opc == OP_ORI) ? DATA_W'(imm) : DATA_W'(signed'(imm));
    valid_d = bus.stall ? valid_q : bus.in_valid;
    op1_d   = bus.stall ? op1_q : rs_data;
    op2_d   = bus.stall ? op2_q : opc == OP_RTYPE ? rt_data : imm_ext;
    sdata_d = bus.stall ? sdata_q : rt_data;
    dest_d  = bus.stall ? dest_q : opc == OP_RTYPE ? rd : (opc == OP_SW || opc == OP_BEQ || opc == OP_BNE) ? '0 : rt;
    funct_d = bus.stall ? funct_q : bus.instruction[FUNCT_W-1:0];
    opc_d   = bus.stall ? opc_q : opc;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= 1'b0;
      op1_q   <= '0;
      op2_q   <= '0;
      sdata_q <= '0;
      dest_q  <= '0;
      funct_q <= '0;
      opc_q   <= '0;
    end else begin
      valid_q <= valid_d;
      op1_q   <= op1_d;
      op2_q   <= op2_d;
      sdata_q <= sdata_d;
      dest_q  <= dest_d;
      funct_q <= funct_d;
      opc_q   <= opc_d;
    end
  assign bus.out_valid  = valid_q;
  assign bus.operand1   = op1_q;
  assign bus.operand2   = op2_q;
  assign bus.store_data = sdata_q;
  assign bus.dest_reg   = dest_q;
  assign bus.funct      = funct_q;
  assign bus.opcode_q   = opc_q;
endmodule

// File: tb/tb_mips_regfile_decode.sv
// tb_mips_regfile_decode: directed checks of decode, register file, stall and reset behaviour.
module tb_mips_regfile_decode;
  import mips_pkg::*;
  logic clk, rst_n;
  int checks = 0, errors = 0;
  mips_regfile_decode_if #(.DATA_W(32), .AW(5)) bus ();
  mips_regfile_decode #(.DATA_W(32), .NUM_REGS(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  typedef struct { logic [31:0] ins; logic [31:0] op1; logic [31:0] op2; logic [4:0] dest; logic [31:0] sd; } vec_t;
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.instruction = 32'h02114020;
    bus.stall = 1'b0;
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'(REG_S0);
    bus.wr_data = 32'h1234;
    cyc();
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.out_valid); end
    checks++; if (bus.operand1 !== 32'h0) begin errors++; $display("FAIL reset_op1: got %h exp 0", bus.operand1); end
    checks++; if (bus.operand2 !== 32'h0) begin errors++; $display("FAIL reset_op2: got %h exp 0", bus.operand2); end
    checks++; if (bus.store_data !== 32'h0) begin errors++; $display("FAIL reset_sd: got %h exp 0", bus.store_data); end
    checks++; if (bus.dest_reg !== 5'h0) begin errors++; $display("FAIL reset_dest: got %h exp 0", bus.dest_reg); end
    checks++; if (bus.funct !== 6'h0 || bus.opcode_q !== 6'h0) begin errors++; $display("FAIL reset_funct_opc: got %h/%h exp 0/0", bus.funct, bus.opcode_q); end
    bus.in_valid = 1'b0;
    bus.wr_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
  endtask
  task automatic test_rtype;
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'(REG_S0);
    bus.wr_data = 32'h2;
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL idle_valid: got %b exp 0", bus.out_valid); end
    bus.wr_addr = 5'(REG_S1);
    bus.wr_data = 32'h3;
    cyc();
    bus.wr_en = 1'b0;
    bus.in_valid = 1'b1;
    bus.instruction = 32'h02114020;
    cyc();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL add_valid: got %b exp 1", bus.out_valid); end
    checks++; if (bus.operand1 !== 32'h2) begin errors++; $display("FAIL add_op1: got %h exp 2", bus.operand1); end
    checks++; if (bus.operand2 !== 32'h3) begin errors++; $display("FAIL add_op2: got %h exp 3", bus.operand2); end
    checks++; if (bus.store_data !== 32'h3) begin errors++; $display("FAIL add_sd: got %h exp 3", bus.store_data); end
    checks++; if (bus.dest_reg !== 5'd8) begin errors++; $display("FAIL add_dest: got %0d exp 8", bus.dest_reg); end
    checks++; if (bus.funct !== 6'h20) begin errors++; $display("FAIL add_funct: got %h exp 20", bus.funct); end
    checks++; if (bus.opcode_q !== 6'h00) begin errors++; $display("FAIL add_opc: got %h exp 00", bus.opcode_q); end
  endtask
  task automatic test_immediates;
    vec_t v [8];
    logic [31:0] ins;
    v[0] = '{32'h2209FFFF, 32'h2, 32'hFFFFFFFF, 5'd9, 32'h0};
    v[1] = '{32'h3609FFFF, 32'h2, 32'h0000FFFF, 5'd9, 32'h0};
    v[2] = '{32'h32098000, 32'h2, 32'h00008000, 5'd9, 32'h0};
    v[3] = '{32'h8E098000, 32'h2, 32'hFFFF8000, 5'd9, 32'h0};
    v[4] = '{32'hAE118000, 32'h2, 32'hFFFF8000, 5'd0, 32'h3};
    v[5] = '{32'h12110004, 32'h2, 32'h00000004, 5'd0, 32'h3};
    v[6] = '{32'h16110004, 32'h2, 32'h00000004, 5'd0, 32'h3};
    v[7] = '{32'h2A09FFFF, 32'h2, 32'hFFFFFFFF, 5'd9, 32'h0};
    for (int i = 0; i < 8; i++) begin
      ins = v[i].ins;
      bus.instruction = ins;
      cyc();
      checks++; if (bus.operand1 !== v[i].op1) begin errors++; $display("FAIL imm%0d_op1: got %h exp %h", i, bus.operand1, v[i].op1); end
      checks++; if (bus.operand2 !== v[i].op2) begin errors++; $display("FAIL imm%0d_op2: got %h exp %h", i, bus.operand2, v[i].op2); end
      checks++; if (bus.dest_reg !== v[i].dest) begin errors++; $display("FAIL imm%0d_dest: got %0d exp %0d", i, bus.dest_reg, v[i].dest); end
      checks++; if (bus.store_data !== v[i].sd) begin errors++; $display("FAIL imm%0d_sd: got %h exp %h", i, bus.store_data, v[i].sd); end
      checks++; if (bus.opcode_q !== ins[31:26]) begin errors++; $display("FAIL imm%0d_opc: got %h exp %h", i, bus.opcode_q, ins[31:26]); end
    end
  endtask
  task automatic test_zero_reg;
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'(REG_ZERO);
    bus.wr_data = 32'hDEAD;
    bus.instruction = 32'h00004020;
    cyc();
    bus.wr_en = 1'b0;
    checks++; if (bus.operand1 !== 32'h0) begin errors++; $display("FAIL zero_same_op1: got %h exp 0", bus.operand1); end
    cyc();
    checks++; if (bus.operand1 !== 32'h0) begin errors++; $display("FAIL zero_after_op1: got %h exp 0", bus.operand1); end
    checks++; if (bus.operand2 !== 32'h0) begin errors++; $display("FAIL zero_after_op2: got %h exp 0", bus.operand2); end
  endtask
  task automatic test_bypass;
    logic [31:0] exp_same;
`ifdef REGFILE_BYPASS_EN
    exp_same = 32'h55;
`else
    exp_same = 32'h3;
`endif
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'(REG_S1);
    bus.wr_data = 32'h55;
    bus.instruction = 32'h02114020;
    cyc();
    bus.wr_en = 1'b0;
    checks++; if (bus.operand2 !== exp_same) begin errors++; $display("FAIL byp_same_op2: got %h exp %h", bus.operand2, exp_same); end
    checks++; if (bus.store_data !== exp_same) begin errors++; $display("FAIL byp_same_sd: got %h exp %h", bus.store_data, exp_same); end
    checks++; if (bus.operand1 !== 32'h2) begin errors++; $display("FAIL byp_same_op1: got %h exp 2", bus.operand1); end
    cyc();
    checks++; if (bus.operand2 !== 32'h55) begin errors++; $display("FAIL byp_next_op2: got %h exp 55", bus.operand2); end
  endtask
  task automatic test_stall;
    bus.stall = 1'b1;
    bus.instruction = 32'h3609FFFF;
    bus.wr_en = 1'b1;
    bus.wr_addr = 5'(REG_S0);
    bus.wr_data = 32'h7;
    for (int i = 0; i < 3; i++) begin
      cyc();
      bus.wr_en = 1'b0;
      checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid: got %b exp 1", i, bus.out_valid); end
      checks++; if (bus.operand1 !== 32'h2) begin errors++; $display("FAIL stall%0d_op1: got %h exp 2", i, bus.operand1); end
      checks++; if (bus.operand2 !== 32'h55) begin errors++; $display("FAIL stall%0d_op2: got %h exp 55", i, bus.operand2); end
      checks++; if (bus.dest_reg !== 5'd8) begin errors++; $display("FAIL stall%0d_dest: got %0d exp 8", i, bus.dest_reg); end
    end
    bus.stall = 1'b0;
    cyc();
    checks++; if (bus.operand2 !== 32'h0000FFFF) begin errors++; $display("FAIL release_op2: got %h exp 0000ffff", bus.operand2); end
    checks++; if (bus.operand1 !== 32'h7) begin errors++; $display("FAIL release_op1: got %h exp 7", bus.operand1); end
    checks++; if (bus.dest_reg !== 5'd9) begin errors++; $display("FAIL release_dest: got %0d exp 9", bus.dest_reg); end
    bus.in_valid = 1'b0;
    cyc();
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL bubble_valid: got %b exp 0", bus.out_valid); end
  endtask
  task automatic test_async_reset;
    bus.in_valid = 1'b1;
    bus.instruction = 32'h02114020;
    cyc();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL pre_rst_valid: got %b exp 1", bus.out_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL arst_valid: got %b exp 0", bus.out_valid); end
    checks++; if (bus.operand1 !== 32'h0 || bus.operand2 !== 32'h0 || bus.store_data !== 32'h0) begin errors++; $display("FAIL arst_data: got %h/%h/%h exp 0/0/0", bus.operand1, bus.operand2, bus.store_data); end
    checks++; if (bus.dest_reg !== 5'h0 || bus.funct !== 6'h0) begin errors++; $display("FAIL arst_ctl: got %h/%h exp 0/0", bus.dest_reg, bus.funct); end
    @(negedge clk);
    rst_n = 1'b1;
    cyc();
    checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL post_rst_valid: got %b exp 1", bus.out_valid); end
    checks++; if (bus.operand1 !== 32'h0) begin errors++; $display("FAIL post_rst_r16: got %h exp 0", bus.operand1); end
    checks++; if (bus.operand2 !== 32'h0) begin errors++; $display("FAIL post_rst_r17: got %h exp 0", bus.operand2); end
  endtask
  initial begin
    test_reset();
    test_rtype();
    test_immediates();
    test_zero_reg();
    test_bypass();
    test_stall();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end
endmodule
